syn_accum: RTL

//   Synaptic current accumulator sitting directly upstream of the two-lane current decay stage.

---
 rtl/syn_pkg.sv | 34 +++
 rtl/syn_event_fifo.sv | 45 ++++
 rtl/syn_accum.sv | 104 ++++++++++
 3 files changed

// File: rtl/syn_pkg.sv
// Shared types and helpers for the synaptic current accumulator.
// Holds the FSM encoding, width defaults and the saturating adder.
package syn_pkg;

  typedef enum logic [1:0] {
    ST_ACC   = 2'd0,
    ST_DRAIN = 2'd1,
    ST_FLUSH = 2'd2
  } state_t;

  localparam int W_DEF  = 16;
  localparam int WW_DEF = 16;
  localparam int XW     = 32;

  // Unsigned acc plus signed weight (both pre-extended to XW),
  // clamped to [0, 2^w-1].
  function automatic logic [XW-1:0] sat_add(
    input logic [XW-1:0] acc,
    input logic [XW-1:0] wt,
    input int unsigned   w
  );
    logic signed [XW+1:0] s;
    logic [XW-1:0]        mx;
    mx = {XW{1'b1}} >> (XW - w);
    s  = $signed({2'b00, acc}) + $signed({{2{wt[XW-1]}}, wt});
    if (s[XW+1])
      sat_add = '0;
    else if (s > $signed({2'b00, mx}))
      sat_add = mx;
    else
      sat_add = s[XW-1:0];
  endfunction

endpackage

// File: rtl/syn_event_fifo.sv
// Small synchronous event FIFO with a combinational head.
// Pointers carry one extra wrap bit to tell full from empty.
module syn_event_fifo #(
  parameter int DW    = 17,
  parameter int DEPTH = 4
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          i_push,
  input  logic [DW-1:0] i_data,
  input  logic          i_pop,
  output logic [DW-1:0] o_head,
  output logic          o_full,
  output logic          o_empty
);

  localparam int AW = $clog2(DEPTH);

  logic [DW-1:0] r_mem [DEPTH];
  logic [AW:0]   r_wr;
  logic [AW:0]   r_rd;

  always_ff @(posedge clk) begin
    if (i_push)
      r_mem[r_wr[AW-1:0]] <= i_data;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr <= '0;
      r_rd <= '0;
    end else begin
      if (i_push)
        r_wr <= r_wr + 1'b1;
      if (i_pop)
        r_rd <= r_rd + 1'b1;
    end
  end

  assign o_head  = r_mem[r_rd[AW-1:0]];
  assign o_empty = (r_wr == r_rd);
  assign o_full  = (r_wr[AW] != r_rd[AW]) &&
                   (r_wr[AW-1:0] == r_rd[AW-1:0]);

endmodule

// File: rtl/syn_accum.sv
// Two-lane synaptic current accumulator feeding the decay stage.
// Sums weighted events per timestep and flushes them with a write strobe.
module syn_accum
  import syn_pkg::*;
#(
  parameter int W     = W_DEF,
  parameter int WW    = WW_DEF,
  parameter int DEPTH = 4
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          ev_valid,
  output logic          ev_ready,
  input  logic          ev_lane,
  input  logic [WW-1:0] ev_weight,
  input  logic          step_end,
  output logic [W-1:0]  curr_out1,
  output logic [W-1:0]  curr_out2,
  output logic          write,
  output logic          step_err
);

  state_t        r_state;
  logic [W-1:0]  r_acc1;
  logic [W-1:0]  r_acc2;

  logic          w_push;
  logic          w_pop;
  logic          w_full;
  logic          w_empty;
  logic [WW:0]   w_head;
  logic          w_lane;
  logic [WW-1:0] w_wt;
  logic [W-1:0]  w_sum;
  logic          w_to_flush;

  assign ev_ready   = (r_state == ST_ACC) && !w_full;
  assign w_push     = ev_valid && ev_ready;
  assign w_pop      = !w_empty && (r_state != ST_FLUSH);
  assign w_to_flush = (r_state == ST_DRAIN) && w_empty;
  assign {w_lane, w_wt} = w_head;

  assign w_sum = W'(sat_add(
    w_lane ? XW'(r_acc2) : XW'(r_acc1),
    XW'($signed(w_wt)),
    W));

  syn_event_fifo #(
    .DW    (WW + 1),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_push  (w_push),
    .i_data  ({ev_lane, ev_weight}),
    .i_pop   (w_pop),
    .o_head  (w_head),
    .o_full  (w_full),
    .o_empty (w_empty)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= ST_ACC;
      r_acc1    <= '0;
      r_acc2    <= '0;
      curr_out1 <= '0;
      curr_out2 <= '0;
      write     <= 1'b0;
      step_err  <= 1'b0;
    end else begin
      write <= 1'b0;
      if (step_end && (r_state != ST_ACC))
        step_err <= 1'b1;
      // Flush only happens with the FIFO empty, so it never races a pop.
      if (w_to_flush) begin
        r_acc1 <= '0;
        r_acc2 <= '0;
      end else if (w_pop) begin
        if (w_lane)
          r_acc2 <= w_sum;
        else
          r_acc1 <= w_sum;
      end
      unique case (r_state)
        ST_ACC: begin
          if (step_end)
            r_state <= ST_DRAIN;
        end
        ST_DRAIN: begin
          if (w_empty) begin
            r_state   <= ST_FLUSH;
            curr_out1 <= r_acc1;
            curr_out2 <= r_acc2;
            write     <= 1'b1;
          end
        end
        ST_FLUSH: r_state <= ST_ACC;
        default:  r_state <= ST_ACC;
      endcase
    end
  end

endmodule
